// File: rtl/r16_pkg.sv
// Shared constants and types for the radix-16 butterfly reduction pipeline.
package r16_pkg;

  localparam int R16_P_WIDTH = 64;

  // Partially reduced value: word plus carry bit.
  typedef logic [R16_P_WIDTH:0]          r16_ext_t;
  // Difference wide enough to hold a borrow as its sign bit.
  typedef logic signed [R16_P_WIDTH+1:0] r16_diff_t;

endpackage

// File: rtl/r16_cond_sub.sv
// Conditional subtraction: y = x - n when that is nonnegative, otherwise x.
module r16_cond_sub #(
  parameter int W = 64
) (
  input  logic [W:0]   x_i,
  input  logic [W-1:0] n_i,
  output logic [W:0]   y_o,
  output logic         nonneg_o
);

  logic [W+1:0] diff;

  always_comb begin
    diff     = {1'b0, x_i} - {2'b00, n_i};
    nonneg_o = ~diff[W+1];
    y_o      = nonneg_o ? diff[W:0] : x_i;
  end

endmodule

// File: rtl/r16_mod_correct_stage.sv
// Two-stage pipelined modular correction with valid/ready back-pressure.
// Optional sticky overflow flag via `define R16_MODCORR_OVF_EN.
module r16_mod_correct_stage
  import r16_pkg::*;
#(
  parameter int                 P_WIDTH = R16_P_WIDTH,
  parameter logic [P_WIDTH-1:0] P_ZERO  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P_WIDTH-1:0] A0_in,
  input  logic               Ac_in,
  input  logic [P_WIDTH-1:0] N_in,
  input  logic [P_WIDTH-1:0] D_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] R_out,
  output logic [P_WIDTH-1:0] N_out,
  output logic [P_WIDTH-1:0] D_out
`ifdef R16_MODCORR_OVF_EN
  ,
  output logic               ovf_out
`endif
);

  logic               v1_q, v1_d, v2_q, v2_d;
  logic [P_WIDTH:0]   x1_q, x1_d;
  logic [P_WIDTH-1:0] n1_q, n1_d, d1_q, d1_d;
  logic [P_WIDTH-1:0] r2_q, r2_d, n2_q, n2_d, d2_q, d2_d;
  logic               en1, en2;

  logic [P_WIDTH:0]   sub1_y, sub2_y;
  logic               sub1_nonneg, sub2_nonneg;

  r16_cond_sub #(.W(P_WIDTH)) u_sub1 (
    .x_i      ({Ac_in, A0_in}),
    .n_i      (N_in),
    .y_o      (sub1_y),
    .nonneg_o (sub1_nonneg)
  );

  r16_cond_sub #(.W(P_WIDTH)) u_sub2 (
    .x_i      (x1_q),
    .n_i      (n1_q),
    .y_o      (sub2_y),
    .nonneg_o (sub2_nonneg)
  );

  // NOTE: every signal assigned here gets its hold value first, so no path
  // through this block can infer a latch.
  always_comb begin
    en2  = ~v2_q | out_ready;
    en1  = ~v1_q | en2;

    v1_d = v1_q;
    x1_d = x1_q;
    n1_d = n1_q;
    d1_d = d1_q;
    v2_d = v2_q;
    r2_d = r2_q;
    n2_d = n2_q;
    d2_d = d2_q;

    if (en1) begin
      v1_d = in_valid;
      x1_d = sub1_y;
      n1_d = N_in;
      d1_d = D_in;
    end
    // Stage 2 keeps only the low word; a set carry here means X was >= 3N.
    if (en2) begin
      v2_d = v1_q;
      r2_d = sub2_y[P_WIDTH-1:0];
      n2_d = n1_q;
      d2_d = d1_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      x1_q <= {1'b0, P_ZERO};
      n1_q <= P_ZERO;
      d1_q <= P_ZERO;
      v2_q <= 1'b0;
      r2_q <= P_ZERO;
      n2_q <= P_ZERO;
      d2_q <= P_ZERO;
    end else begin
      v1_q <= v1_d;
      x1_q <= x1_d;
      n1_q <= n1_d;
      d1_q <= d1_d;
      v2_q <= v2_d;
      r2_q <= r2_d;
      n2_q <= n2_d;
      d2_q <= d2_d;
    end
  end

  assign in_ready  = en1;
  assign out_valid = v2_q;
  assign R_out     = r2_q;
  assign N_out     = n2_q;
  assign D_out     = d2_q;

`ifdef R16_MODCORR_OVF_EN
  logic ovf_q, ovf_d, ovf_hit;

  // A second subtraction that still leaves a value >= N means X >= 3N.
  always_comb begin
    ovf_hit = sub2_nonneg & (sub2_y >= {1'b0, n1_q});
    ovf_d   = ovf_q | (en2 & v1_q & ovf_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf_out = ovf_q;
`else
  logic unused_sub2;
  assign unused_sub2 = ^{sub2_y[P_WIDTH], sub2_nonneg};
`endif

endmodule

// File: tb/tb_r16_mod_correct_stage.sv
// Self-checking bench for r16_mod_correct_stage: directed cases plus random
// traffic scored against an arithmetic reference queue.
module tb_r16_mod_correct_stage;
  import r16_pkg::*;

  localparam int W = R16_P_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A0_in = '0;
  logic         Ac_in = 1'b0;
  logic [W-1:0] N_in = '0;
  logic [W-1:0] D_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] R_out, N_out, D_out;
`ifdef R16_MODCORR_OVF_EN
  logic         ovf_out;
`endif

  r16_mod_correct_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A0_in     (A0_in),
    .Ac_in     (Ac_in),
    .N_in      (N_in),
    .D_in      (D_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R_out     (R_out),
    .N_out     (N_out),
    .D_out     (D_out)
`ifdef R16_MODCORR_OVF_EN
    ,
    .ovf_out   (ovf_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic         ovf;
    int           cyc;
  } beat_t;

  beat_t queue_m[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  logic  exp_ovf  = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: reduce X by N at most twice, keep the low word; X >= 3N is overflow.
  function automatic beat_t ref_beat(input r16_ext_t x, input logic [W-1:0] n, input logic [W-1:0] d);
    beat_t b;
    logic [127:0] xx, nn, rr;
    xx = 128'(x);
    nn = 128'(n);
    if (xx >= 2 * nn)  rr = xx - 2 * nn;
    else if (xx >= nn) rr = xx - nn;
    else               rr = xx;
    b.r   = rr[W-1:0];
    b.n   = n;
    b.d   = d;
    b.ovf = (xx >= 3 * nn);
    b.cyc = 0;
    return b;
  endfunction

  // One clock cycle: drive at negedge, score 1 ns later, update the model.
  task automatic do_cycle(input logic iv, input r16_ext_t x, input logic [W-1:0] n,
                          input logic [W-1:0] d, input logic ordy, output logic acc);
    logic  exp_ov, exp_ir;
    beat_t b;
    @(negedge clk);
    in_valid  = iv;
    {Ac_in, A0_in} = x;
    N_in      = n;
    D_in      = d;
    out_ready = ordy;
    #1;
    exp_ov = (queue_m.size() > 0) && (cyc >= queue_m[0].cyc + 2);
    exp_ir = (queue_m.size() < 2) || ordy;
    check("out_valid", 128'(out_valid), 128'(exp_ov));
    check("in_ready", 128'(in_ready), 128'(exp_ir));
    if (exp_ov) begin
      check("R_out", 128'(R_out), 128'(queue_m[0].r));
      check("N_out", 128'(N_out), 128'(queue_m[0].n));
      check("D_out", 128'(D_out), 128'(queue_m[0].d));
      if (queue_m[0].ovf) exp_ovf = 1'b1;
    end
`ifdef R16_MODCORR_OVF_EN
    check("ovf_out", 128'(ovf_out), 128'(exp_ovf));
`endif
    acc = iv & exp_ir;
    if (exp_ov && ordy) void'(queue_m.pop_front());
    if (acc) begin
      b = ref_beat(x, n, d);
      b.cyc = cyc;
      queue_m.push_back(b);
    end
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    logic a;
    do_cycle(1'b0, '0, '0, '0, ordy, a);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_R_out"}, 128'(R_out), 128'(0));
    check({tag, "_N_out"}, 128'(N_out), 128'(0));
    check({tag, "_D_out"}, 128'(D_out), 128'(0));
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
`ifdef R16_MODCORR_OVF_EN
    check({tag, "_ovf_out"}, 128'(ovf_out), 128'(0));
`endif
  endtask

  initial begin
    logic         a;
    int           accepted;
    int           k;
    logic [W-1:0] n;
    logic [127:0] rnd, lim;
    r16_ext_t     x;

    // Reset held for a few cycles.
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Single beat: 5 mod 17.
    do_cycle(1'b1, 65'd5, 64'd17, 64'hAA, 1'b1, a);
    check("t1_accept", 128'(a), 128'(1));
    idle(1'b1);
    idle(1'b1);
    check("t1_valid", 128'(out_valid), 128'(1));
    check("t1_R", 128'(R_out), 128'(5));
    check("t1_D", 128'(D_out), 128'(64'hAA));
    idle(1'b1);
    check("t1_valid_one_cycle", 128'(out_valid), 128'(0));

    // Back-to-back: one subtraction, then two.
    do_cycle(1'b1, 65'd20, 64'd17, 64'h1, 1'b1, a);
    do_cycle(1'b1, 65'd40, 64'd17, 64'h2, 1'b1, a);
    idle(1'b1);
    check("t2_R0", 128'(R_out), 128'(3));
    idle(1'b1);
    check("t2_R1", 128'(R_out), 128'(6));
    idle(1'b1);

    // Carry bit set, large modulus.
    do_cycle(1'b1, {1'b1, 64'h0}, 64'hFFFF_FFFF_0000_0001, 64'h3, 1'b1, a);
    idle(1'b1);
    idle(1'b1);
    check("t3_R", 128'(R_out), 128'(64'h0000_0000_FFFF_FFFF));
    idle(1'b1);

    // Stall: offer 4 beats with out_ready low, then drain.
    accepted = 0;
    k = 0;
    repeat (4) begin
      do_cycle(1'b1, 65'(50 + accepted), 64'd17, 64'(accepted), 1'b0, a);
      if (a) accepted++;
    end
    check("stall_accepted", 128'(accepted), 128'(2));
    check("stall_in_ready", 128'(in_ready), 128'(0));
    check("stall_R_held", 128'(R_out), 128'(16));
    while (accepted < 4 && k < 20) begin
      do_cycle(1'b1, 65'(50 + accepted), 64'd17, 64'(accepted), 1'b1, a);
      if (a) accepted++;
      k++;
    end
    check("stall_drain_accepted", 128'(accepted), 128'(4));
    k = 0;
    while (queue_m.size() > 0 && k < 10) begin
      idle(1'b1);
      k++;
    end
    check("stall_drained", 128'(queue_m.size()), 128'(0));

    // Random traffic with X < 3N, random back-pressure.
    repeat (400) begin
      n = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) n = 64'($urandom_range(1, 1000));
      if (n == 0) n = 64'd1;
      rnd = {$urandom, $urandom, $urandom, $urandom};
      lim = 3 * 128'(n);
      if (lim > (128'd1 << 65)) lim = 128'd1 << 65;
      rnd = rnd % lim;
      x = rnd[W:0];
      do_cycle($urandom_range(0, 9) < 7, x, n, {$urandom, $urandom},
               $urandom_range(0, 9) < 7, a);
    end
    k = 0;
    while (queue_m.size() > 0 && k < 10) begin
      idle(1'b1);
      k++;
    end
    check("random_drained", 128'(queue_m.size()), 128'(0));

`ifdef R16_MODCORR_OVF_EN
    // Overflow: 60 >= 3*17; flag stays set across later beats.
    do_cycle(1'b1, 65'd60, 64'd17, 64'h5, 1'b1, a);
    idle(1'b1);
    idle(1'b1);
    check("ovf_R", 128'(R_out), 128'(26));
    check("ovf_set", 128'(ovf_out), 128'(1));
    do_cycle(1'b1, 65'd3, 64'd17, 64'h6, 1'b1, a);
    do_cycle(1'b1, 65'd4, 64'd17, 64'h7, 1'b1, a);
    idle(1'b1);
    idle(1'b1);
    check("ovf_sticky", 128'(ovf_out), 128'(1));
`endif

    // Reset with two beats in flight.
    do_cycle(1'b1, 65'd30, 64'd17, 64'h8, 1'b0, a);
    do_cycle(1'b1, 65'd31, 64'd17, 64'h9, 1'b0, a);
    idle(1'b0);
    check("pre_reset_valid", 128'(out_valid), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    queue_m.delete();
    exp_ovf = 1'b0;
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    repeat (4) idle(1'b1);
    check("post_reset_idle", 128'(out_valid), 128'(0));
    do_cycle(1'b1, 65'd35, 64'd17, 64'hB, 1'b1, a);
    idle(1'b1);
    idle(1'b1);
    check("post_reset_R", 128'(R_out), 128'(1));
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/r16_mod_correct_stage.md
# r16_mod_correct_stage

Final modular-correction stage of the radix-16 butterfly reduction pipeline, directly downstream of pipe register 4_2. It consumes the partially reduced value (low word `A0`, carry bit `Ac`), the modulus `N` and the side-band operand `D`, and performs up to two pipelined conditional subtractions of `N`. It emits a fully reduced result in `[0, N)` with a valid/ready handshake. Two register stages with back-pressure let the butterfly output FIFO stall the reduction path without losing data.

## Interface
- `P_WIDTH`, 64: datapath width of `A0`, `N`, `D` and the result.
- `P_ZERO`, `64'h0`: reset/clear value for wide registers.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the upstream beat is valid.
- `in_ready` output 1: the stage accepts the beat this cycle.
- `A0_in` input P_WIDTH: low word of the partially reduced value.
- `Ac_in` input 1: carry bit (bit P_WIDTH) of the partially reduced value.
- `N_in` input P_WIDTH: modulus; must be nonzero.
- `D_in` input P_WIDTH: side-band operand, carried with the value unmodified.
- `out_valid` output 1: the result beat is valid.
- `out_ready` input 1: downstream accepts the result.
- `R_out` output P_WIDTH: reduced result.
- `N_out` output P_WIDTH: modulus aligned with `R_out`.
- `D_out` output P_WIDTH: `D` aligned with `R_out`.
- `ovf_out` output 1: sticky reduction-overflow flag. Present only with `R16_MODCORR_OVF_EN`.

## Operation
- Input value X = {Ac_in, A0_in}, P_WIDTH+1 bits, unsigned.
- Stage 1:
  - T1 = X − N, computed P_WIDTH+2 bits wide.
  - If T1 ≥ 0 (sign bit clear), X1 = T1; otherwise X1 = X.
  - Register X1 (P_WIDTH+1 bits), N, D and valid bit v1.
- Stage 2:
  - T2 = X1 − N, computed P_WIDTH+2 bits wide.
  - R = T2[P_WIDTH-1:0] if T2 ≥ 0; otherwise X1[P_WIDTH-1:0].
  - Register R, N, D and valid bit v2 (`out_valid` = v2).
- Correct for X < 3N. Behaviour for X ≥ 3N is the truncated R, flagged only when the overflow feature is compiled in.
- Handshake:
  - en2 = ~v2 | out_ready.
  - en1 = ~v1 | en2.
  - `in_ready` = en1, combinational from `out_ready` and the state bits.
- Transfer rules:
  - Input is accepted when `in_valid & in_ready`.
  - Stage 1 loads on en1, and v1 takes the value of `in_valid`.
  - Stage 2 loads on en2, and v2 takes the value of v1.
  - A beat is delivered when `out_valid & out_ready`.
- Data registers hold when their enable is low. `R_out`, `N_out` and `D_out` stay stable while `out_valid & ~out_ready`.
- Simultaneous accept and deliver in the same cycle is full throughput with no bubble.
- Ordering is strictly first-in, first-out. There is no drop and no duplication.

## Timing
- Latency is 2 cycles: a beat accepted at edge k appears with `out_valid` = 1 after edge k+2 when `out_ready` stays high.
- Throughput is 1 beat per cycle.
- Capacity is 2 beats. With `out_ready` low, `in_ready` falls after two accepted beats.
- Reset, asynchronous on `rst_n` low: v1 = v2 = 0, all data registers = P_ZERO, `ovf_out` = 0.
  - Outputs read `out_valid` = 0, `R_out` = `N_out` = `D_out` = 0, `in_ready` = 1.
  - In-flight beats are discarded.
- First accept after reset release is on the first rising edge with `rst_n` high.

## Configuration
- `R16_MODCORR_OVF_EN` defined:
  - In stage 2, when T2 ≥ 0 and T2[P_WIDTH:0] ≥ N, the input exceeded 3N−1.
  - `ovf_out` is set on the cycle that beat loads into stage 2 and stays set until reset.
- Not defined: the `ovf_out` port, the compare logic and the flag register are absent. Datapath and timing are identical in both builds.

## Structure
- Shared package `r16_pkg`:
  - `P_WIDTH` default.
  - Typedef for the P_WIDTH+1 extended value.
  - Typedef for the P_WIDTH+2 signed difference.
- One sub-module, `r16_cond_sub`, used once per stage:
  - Combinational: input X (P_WIDTH+1 bits) and N; output X−N if nonnegative, else X, plus a nonnegative flag.

## Test plan
- A0_in=5, Ac_in=0, N=17, D=0xAA, single beat, `out_ready`=1 → after 2 cycles R_out=5, D_out=0xAA, `out_valid` high for 1 cycle.
- A0_in=20, then A0_in=40, N=17, back-to-back beats → R_out=3 then 6 on consecutive cycles (one subtraction, then two).
- Ac_in=1, A0_in=0, N=0xFFFFFFFF00000001 → R_out=0x00000000FFFFFFFF.
- Stall: 4 beats offered with `out_ready`=0 → 2 accepted, `in_ready`=0, R_out held stable. `out_ready`=1 → all 4 delivered in order with no gaps.
- With `R16_MODCORR_OVF_EN`: N=17, A0_in=60 → R_out=26, `ovf_out`=1 and still 1 after later valid beats.
- `rst_n` asserted with 2 beats in flight → immediately `out_valid`=0, `R_out`=0, `in_ready`=1. No stale beat appears after release.
